hazard_scoreboard: RTL and testbench

//  Parametrised hazard/forwarding unit for the pipelined MIPS core.

---
 rtl/hazard_scoreboard.sv | 144 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard detection and operand forwarding for the pipelined MIPS core.
// A DEPTH-entry shift scoreboard records the in-flight register writes in stages 1..DEPTH (EXE..WB).
// Each ID read port gets a forwarding select. A load-use hazard stalls ID, and issue reports
// when the ID instruction moves into EXE.
// Optional build macro: HAZARD_STATS_EN adds saturating stall and forward event counters.
// Without the macro, stat_* are tied to zero.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   id_valid/id_ra/id_ruse ID instruction presence, source registers, per-port read enables
//   id_wa/id_wr/id_load    ID destination register, write enable, load flag
//   flush, ext_stall       kill the ID instruction / freeze the whole pipeline
//   fwd_sel                per port: 0 = regfile, k = forward from stage k
//   hz_stall, issue        load-use stall / ID advances into EXE
//   stat_stall, stat_fwd   event counters (only built with HAZARD_STATS_EN)
module hazard_scoreboard #(
  parameter int unsigned AW       = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned SW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [NRD*AW-1:0] id_ra,
  input  logic [NRD-1:0]    id_ruse,
  input  logic [AW-1:0]     id_wa,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              flush,
  input  logic              ext_stall,
  output logic [NRD*SW-1:0] fwd_sel,
  output logic              hz_stall,
  output logic              issue,
  output logic [31:0]       stat_stall,
  output logic [31:0]       stat_fwd
);

  // Scoreboard storage: index k holds stage k+1.
  logic [DEPTH-1:0]         v_q, v_d;
  logic [DEPTH-1:0]         ld_q, ld_d;
  logic [DEPTH-1:0][AW-1:0] wa_q, wa_d;

  logic [NRD-1:0]         hit;
  logic [NRD-1:0]         port_hz;
  logic [NRD-1:0][SW-1:0] raw_sel;
  logic                   any_hz;

  // Per-port match search. Stages are scanned youngest-first, so the first hit is the winner.
  always_comb begin
    hit     = '0;
    port_hz = '0;
    raw_sel = '0;
    for (int p = 0; p < int'(NRD); p++) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (!hit[p] && id_ruse[p] && (id_ra[p*AW +: AW] != '0) &&
            v_q[k] && (wa_q[k] == id_ra[p*AW +: AW])) begin
          hit[p]     = 1'b1;
          raw_sel[p] = SW'(k + 1);
          // A load is not forwardable until it has left stages 1..LOAD_LAT.
          port_hz[p] = ld_q[k] && ((k + 1) <= int'(LOAD_LAT));
        end
      end
    end
  end

  // Output decode. A hazard port reads the regfile (sel 0). Reset forces idle outputs.
  always_comb begin
    fwd_sel = '0;
    any_hz  = |port_hz;
    for (int p = 0; p < int'(NRD); p++) begin
      fwd_sel[p*SW +: SW] = (rst || port_hz[p]) ? '0 : raw_sel[p];
    end
    hz_stall = id_valid & ~flush & any_hz & ~rst;
    issue    = id_valid & ~flush & ~any_hz & ~ext_stall & ~rst;
  end

  // Shift the scoreboard unless frozen. A bubble enters when ID does not issue.
  always_comb begin
    v_d  = v_q;
    ld_d = ld_q;
    wa_d = wa_q;
    if (!ext_stall) begin
      for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
        v_d[k]  = v_q[k-1];
        ld_d[k] = ld_q[k-1];
        wa_d[k] = wa_q[k-1];
      end
      v_d[0]  = issue & id_wr & (id_wa != '0);
      ld_d[0] = issue & id_load;
      wa_d[0] = issue ? id_wa : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      ld_q <= '0;
      wa_q <= '0;
    end else begin
      v_q  <= v_d;
      ld_q <= ld_d;
      wa_q <= wa_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stat_stall_q, stat_stall_d;
  logic [31:0] stat_fwd_q, stat_fwd_d;
  logic [31:0] nfwd;
  logic [32:0] fwd_sum;

  // Saturating counters: stall cycles and issued operands that are forwarded.
  always_comb begin
    nfwd = '0;
    for (int p = 0; p < int'(NRD); p++) begin
      nfwd = nfwd + 32'(fwd_sel[p*SW +: SW] != '0);
    end
    fwd_sum      = {1'b0, stat_fwd_q} + 33'(issue ? nfwd : 32'd0);
    stat_fwd_d   = fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
    stat_stall_d = stat_stall_q;
    if (hz_stall && !ext_stall && (stat_stall_q != 32'hFFFF_FFFF)) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_q <= '0;
      stat_fwd_q   <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_fwd_q   <= stat_fwd_d;
    end
  end

  assign stat_stall = stat_stall_q;
  assign stat_fwd   = stat_fwd_q;
`else
  assign stat_stall = '0;
  assign stat_fwd   = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: runs two scoreboard configurations from the same ID stimulus.
// Configuration a: DEPTH=3, NRD=2, LOAD_LAT=1. Configuration b: DEPTH=5, NRD=3, LOAD_LAT=2.
// A queue model of in-flight writers checks both instances every cycle.
// Directed table rows and hand-written sequences are also checked against fixed values.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_wr, id_load, flush, ext_stall;
  logic [4:0] ra [3];
  logic [2:0] ruse;
  logic [4:0] id_wa;
  logic [9:0]  id_ra_a;
  logic [14:0] id_ra_b;
  assign id_ra_a = {ra[1], ra[0]};
  assign id_ra_b = {ra[2], ra[1], ra[0]};

  logic [3:0]  fsel_a;
  logic [8:0]  fsel_b;
  logic        hz_a, iss_a, hz_b, iss_b;
  logic [31:0] ss_a, sf_a, ss_b, sf_b;

  hazard_scoreboard #(.AW(5), .NRD(2), .DEPTH(3), .LOAD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra_a), .id_ruse(ruse[1:0]),
    .id_wa(id_wa), .id_wr(id_wr), .id_load(id_load), .flush(flush), .ext_stall(ext_stall),
    .fwd_sel(fsel_a), .hz_stall(hz_a), .issue(iss_a), .stat_stall(ss_a), .stat_fwd(sf_a));

  hazard_scoreboard #(.AW(5), .NRD(3), .DEPTH(5), .LOAD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra_b), .id_ruse(ruse),
    .id_wa(id_wa), .id_wr(id_wr), .id_load(id_load), .flush(flush), .ext_stall(ext_stall),
    .fwd_sel(fsel_b), .hz_stall(hz_b), .issue(iss_b), .stat_stall(ss_b), .stat_fwd(sf_b));

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  // Reference model: per instance, a list of in-flight writers, youngest first.
  bit          mv  [2][5];
  bit          mld [2][5];
  logic [4:0]  mwa [2][5];
  longint      mstall [2];
  longint      mfwd [2];
  int          esel [2][3];
  bit          ehz [2];
  bit          eiss [2];

  function automatic int depth(int i);  return (i == 0) ? 3 : 5; endfunction
  function automatic int lat(int i);    return (i == 0) ? 1 : 2; endfunction
  function automatic int nports(int i); return (i == 0) ? 2 : 3; endfunction

  function automatic void eval(int i);
    bit anyh = 1'b0;
    for (int p = 0; p < 3; p++) begin
      esel[i][p] = 0;
      if (p < nports(i) && ruse[p] && ra[p] != 5'd0) begin
        for (int k = 0; k < depth(i); k++) begin
          if (mv[i][k] && mwa[i][k] == ra[p]) begin
            if (mld[i][k] && (k + 1) <= lat(i)) anyh = 1'b1;
            else esel[i][p] = k + 1;
            break;
          end
        end
      end
      if (rst) esel[i][p] = 0;
    end
    ehz[i]  = id_valid && !flush && anyh && !rst;
    eiss[i] = id_valid && !flush && !anyh && !ext_stall && !rst;
  endfunction

  function automatic longint exp_stat(longint v);
`ifdef HAZARD_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Let the outputs settle, then compare both instances against the model.
  task automatic settle();
    #1;
    for (int i = 0; i < 2; i++) begin
      eval(i);
      for (int p = 0; p < nports(i); p++) begin
        chk($sformatf("m%0d_sel%0d", i, p),
            (i == 0) ? longint'(fsel_a[p*2 +: 2]) : longint'(fsel_b[p*3 +: 3]), esel[i][p]);
      end
      chk($sformatf("m%0d_hz", i),  (i == 0) ? hz_a : hz_b, ehz[i]);
      chk($sformatf("m%0d_iss", i), (i == 0) ? iss_a : iss_b, eiss[i]);
      chk($sformatf("m%0d_sstall", i), (i == 0) ? ss_a : ss_b, exp_stat(mstall[i]));
      chk($sformatf("m%0d_sfwd", i),   (i == 0) ? sf_a : sf_b, exp_stat(mfwd[i]));
    end
  endtask

  // Apply the clock edge to the model, then move to the next drive point.
  task automatic advance();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int k = 0; k < 5; k++) begin mv[i][k] = 0; mld[i][k] = 0; mwa[i][k] = 0; end
        mstall[i] = 0;
        mfwd[i]   = 0;
      end else begin
        if (ehz[i] && !ext_stall) mstall[i]++;
        if (eiss[i]) for (int p = 0; p < 3; p++) if (esel[i][p] != 0) mfwd[i]++;
        if (!ext_stall) begin
          for (int k = depth(i) - 1; k >= 1; k--) begin
            mv[i][k] = mv[i][k-1]; mld[i][k] = mld[i][k-1]; mwa[i][k] = mwa[i][k-1];
          end
          mv[i][0]  = eiss[i] && id_wr && id_wa != 5'd0;
          mld[i][0] = id_load;
          mwa[i][0] = id_wa;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [1:0] ru, input logic [4:0] wa, input bit wr,
                       input bit ld, input bit fl, input bit ex);
    id_valid = v; ra[0] = r0; ra[1] = r1; ra[2] = 5'd0; ruse = {1'b0, ru};
    id_wa = wa; id_wr = wr; id_load = ld; flush = fl; ext_stall = ex;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    advance();
    rst = 1'b0;
  endtask

  typedef struct {
    bit v; logic [4:0] r0; logic [4:0] r1; logic [1:0] ru; logic [4:0] wa; bit wr; bit ld;
    int s0; int s1; bit hz; bit iss;
  } vec_t;
  vec_t tbl [10];

  initial begin
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin mstall[i] = 0; mfwd[i] = 0; end
    for (int i = 0; i < 2; i++) for (int k = 0; k < 5; k++) begin
      mv[i][k] = 0; mld[i][k] = 0; mwa[i][k] = 0;
    end
    @(negedge clk);
    // Reset holds outputs idle even with a valid ID instruction.
    settle();
    chk("rst_issue", iss_a, 0);
    chk("rst_hz", hz_a, 0);
    chk("rst_sel", fsel_a, 0);
    advance();
    rst = 1'b0;

    // Directed rows: v, ra0, ra1, ruse, wa, wr, ld, sel0, sel1, hz, issue.
    tbl[0] = '{1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0, 1};
    tbl[1] = '{1, 3, 1, 2'b11, 4, 1, 0, 1, 0, 0, 1};
    tbl[2] = '{1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0, 1};
    tbl[3] = '{1, 5, 3, 2'b11, 6, 1, 0, 0, 3, 1, 0};
    tbl[4] = '{1, 5, 3, 2'b11, 6, 1, 0, 2, 0, 0, 1};
    tbl[5] = '{1, 0, 0, 2'b00, 7, 1, 0, 0, 0, 0, 1};
    tbl[6] = '{1, 6, 0, 2'b01, 7, 1, 0, 2, 0, 0, 1};
    tbl[7] = '{1, 7, 7, 2'b11, 0, 1, 0, 1, 1, 0, 1};
    tbl[8] = '{1, 0, 7, 2'b01, 0, 0, 0, 0, 0, 0, 1};
    tbl[9] = '{0, 7, 0, 2'b01, 0, 0, 0, 3, 0, 0, 0};
    for (int r = 0; r < 10; r++) begin
      drive(tbl[r].v, tbl[r].r0, tbl[r].r1, tbl[r].ru, tbl[r].wa, tbl[r].wr, tbl[r].ld, 0, 0);
      settle();
      chk($sformatf("row%0d_sel0", r), fsel_a[1:0], tbl[r].s0);
      chk($sformatf("row%0d_sel1", r), fsel_a[3:2], tbl[r].s1);
      chk($sformatf("row%0d_hz", r), hz_a, tbl[r].hz);
      chk($sformatf("row%0d_iss", r), iss_a, tbl[r].iss);
      advance();
    end
    chk("row_stat_stall", ss_a, exp_stat(1));

    // Load-use hazard held by ext_stall for 3 cycles: nothing moves.
    do_reset();
    drive(1, 0, 0, 0, 5, 1, 1, 0, 0); settle(); advance();
    for (int c = 0; c < 3; c++) begin
      drive(1, 5, 0, 2'b01, 6, 1, 0, 0, 1);
      settle();
      chk($sformatf("ext%0d_hz", c), hz_a, 1);
      chk($sformatf("ext%0d_iss", c), iss_a, 0);
      advance();
    end
    drive(1, 5, 0, 2'b01, 6, 1, 0, 0, 0);
    settle();
    chk("ext_frozen_hz", hz_a, 1);
    advance();
    settle();
    chk("ext_after_sel0", fsel_a[1:0], 2);
    chk("ext_after_iss", iss_a, 1);
    chk("ext_stat_stall", ss_a, exp_stat(1));
    advance();

    // The same hazard with flush: no stall, no issue, a bubble enters stage 1.
    do_reset();
    drive(1, 0, 0, 0, 5, 1, 1, 0, 0); settle(); advance();
    drive(1, 5, 0, 2'b01, 5, 1, 0, 1, 0);
    settle();
    chk("flush_hz", hz_a, 0);
    chk("flush_iss", iss_a, 0);
    advance();
    drive(0, 5, 0, 2'b01, 0, 0, 0, 0, 0);
    settle();
    chk("flush_bubble_sel0", fsel_a[1:0], 2);
    advance();

    // Reset with three live writers: they are all forgotten.
    do_reset();
    for (int r = 1; r <= 3; r++) begin
      drive(1, 0, 0, 0, 5'(r), 1, 1, 0, 0); settle(); advance();
    end
    rst = 1'b1;
    drive(1, 1, 2, 2'b11, 4, 1, 0, 0, 0);
    settle();
    chk("midrst_iss", iss_a, 0);
    advance();
    rst = 1'b0;
    settle();
    chk("postrst_sel", fsel_a, 0);
    chk("postrst_hz", hz_a, 0);
    chk("postrst_stat", ss_a, 0);
    advance();

    // Random traffic over a small register range so matches are frequent.
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 79) == 0);
      id_valid  = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 3; p++) ra[p] = 5'($urandom_range(0, 7));
      ruse      = 3'($urandom);
      id_wa     = 5'($urandom_range(0, 7));
      id_wr     = ($urandom_range(0, 4) != 0);
      id_load   = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      ext_stall = ($urandom_range(0, 5) == 0);
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
